// File: rtl/stream_demux_1xn.sv
// rtl/stream_demux_1xn.sv - registered 1-to-N valid/ready stream demultiplexer with optional packet lock
module stream_demux_1xn #(
    parameter int WIDTH    = 8,
    parameter int SEL_W    = 3,
    parameter int PKT_MODE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [(2**SEL_W)*WIDTH-1:0]   out_data,
    output logic [(2**SEL_W)-1:0]         out_last,
    output logic [(2**SEL_W)-1:0]         out_valid,
    input  logic [(2**SEL_W)-1:0]         out_ready,
    output logic                          busy,
    output logic [SEL_W-1:0]              cur_sel
);

    localparam int N = 2**SEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SEL_W-1:0]     r_lock_sel;
    logic [SEL_W-1:0]     w_lock_sel_nxt;
    logic [N*WIDTH-1:0]   r_data;
    logic [N-1:0]         r_last;
    logic [N-1:0]         r_valid;
    logic [SEL_W-1:0]     w_route;
    logic                 w_accept;
    logic                 w_last_in;
    logic [N-1:0]         w_load;

    // Route: locked channel while inside a packet, otherwise the live select.
    assign w_route   = (PKT_MODE != 0 && r_state == PKT) ? r_lock_sel : in_sel;

    // Only the routed channel's register gates the input, so a stalled
    // channel never blocks traffic headed elsewhere.
    assign in_ready  = !rst && (!r_valid[w_route] || out_ready[w_route]);
    assign w_accept  = in_valid && in_ready;
    assign w_last_in = (PKT_MODE != 0) ? in_last : 1'b0;
    assign w_load    = {{(N-1){1'b0}}, w_accept} << w_route;

    assign out_data  = r_data;
    assign out_last  = r_last;
    assign out_valid = r_valid;
    assign busy      = (r_state == PKT);
    assign cur_sel   = w_route;

    // Packet FSM next state: lock the route on a non-final first beat, release on the last beat.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_sel_nxt = r_lock_sel;
        if (PKT_MODE != 0 && w_accept) begin
            case (r_state)
                IDLE: begin
                    if (!in_last) begin
                        w_state_nxt    = PKT;
                        w_lock_sel_nxt = in_sel;
                    end
                end
                PKT: begin
                    if (in_last) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM state and locked route registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock_sel <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_sel <= w_lock_sel_nxt;
        end
    end

    // Per-channel one-entry output registers: a load wins over a drain, and
    // payload only changes on a load so stalled beats stay stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_last  <= '0;
            r_valid <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_load[k]) begin
                    r_data[k*WIDTH +: WIDTH] <= in_data;
                    r_last[k]                <= w_last_in;
                    r_valid[k]               <= 1'b1;
                end else if (out_ready[k]) begin
                    r_valid[k]               <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// tb/tb_stream_demux_1xn.sv - scoreboard bench for stream_demux_1xn in per-beat and packet modes
module tb_stream_demux_1xn;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data   [2];
    logic [2:0]  in_sel    [2];
    logic        in_valid  [2];
    logic        in_last   [2];
    logic        in_ready  [2];
    logic [63:0] out_data  [2];
    logic [7:0]  out_last  [2];
    logic [7:0]  out_valid [2];
    logic [7:0]  out_ready [2];
    logic        busy      [2];
    logic [2:0]  cur_sel   [2];

    int n_tests;
    int n_fail;
    logic mon_en;
    logic rnd_en;

    // reference model state
    logic [8:0]  sb_q  [2][8][$];
    logic [7:0]  m_occ [2];
    logic        m_pkt [2];
    logic [2:0]  m_lock[2];
    int          recv  [2][8];
    logic [2:0]  mr;
    logic        mrdy;
    logic [8:0]  mexp;

    stream_demux_1xn #(.WIDTH(8), .SEL_W(3), .PKT_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_sel(in_sel[0]),
        .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_last(out_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .busy(busy[0]), .cur_sel(cur_sel[0])
    );

    stream_demux_1xn #(.WIDTH(8), .SEL_W(3), .PKT_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_sel(in_sel[1]),
        .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_last(out_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .busy(busy[1]), .cur_sel(cur_sel[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model and scoreboard, evaluated mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                mr   = (i == 1 && m_pkt[i]) ? m_lock[i] : in_sel[i];
                mrdy = !rst && (!m_occ[i][mr] || out_ready[i][mr]);
                check($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(mrdy));
                check($sformatf("cur_sel%0d", i), 32'(cur_sel[i]), 32'(mr));
                check($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_pkt[i]));
                for (int k = 0; k < 8; k++) begin
                    check($sformatf("out_valid%0d[%0d]", i, k), 32'(out_valid[i][k]), 32'(m_occ[i][k]));
                    if (m_occ[i][k] && sb_q[i][k].size() > 0) begin
                        mexp = sb_q[i][k][0];
                        check($sformatf("beat%0d[%0d]", i, k),
                              32'({out_last[i][k], out_data[i][k*8 +: 8]}), 32'(mexp));
                        if (out_ready[i][k]) begin
                            void'(sb_q[i][k].pop_front());
                            recv[i][k]++;
                            m_occ[i][k] = 1'b0;
                        end
                    end
                end
                if (rst) begin
                    m_occ[i]  = '0;
                    m_pkt[i]  = 1'b0;
                    m_lock[i] = '0;
                    for (int k = 0; k < 8; k++) sb_q[i][k].delete();
                end else if (in_valid[i] && mrdy) begin
                    sb_q[i][mr].push_back({(i == 1) ? in_last[i] : 1'b0, in_data[i]});
                    m_occ[i][mr] = 1'b1;
                    if (i == 1) begin
                        if (!m_pkt[i] && !in_last[i]) begin
                            m_pkt[i]  = 1'b1;
                            m_lock[i] = in_sel[i];
                        end else if (m_pkt[i] && in_last[i]) begin
                            m_pkt[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // random consumer backpressure
    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            out_ready[0] = 8'($urandom);
            out_ready[1] = 8'($urandom);
        end
    end

    task automatic send(input int i, input logic [2:0] s, input logic [7:0] d, input logic l);
        in_sel[i]   = s;
        in_data[i]  = d;
        in_last[i]  = l;
        in_valid[i] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready[i]) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; mon_en = 1'b0; rnd_en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data[i] = '0; in_sel[i] = '0; in_valid[i] = 1'b0; in_last[i] = 1'b0;
            out_ready[i] = 8'hFF; m_occ[i] = '0; m_pkt[i] = 1'b0; m_lock[i] = '0;
            for (int k = 0; k < 8; k++) recv[i][k] = 0;
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("rst_data0", 32'(out_data[0][31:0]), 32'd0);
        check("rst_data1", 32'(out_data[1][63:32]), 32'd0);
        check("rst_last", 32'({out_last[0], out_last[1]}), 32'd0);
        @(negedge clk);
        check("rst_in_ready", 32'({in_ready[0], in_ready[1]}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // per-beat routing to every channel; in_last must be ignored in mode 0
        for (int k = 0; k < 8; k++) send(0, 3'(k), 8'(8'hA0 + k), 1'(k & 1));
        idle(2);
        for (int k = 0; k < 8; k++) check($sformatf("route_cnt[%0d]", k), 32'(recv[0][k]), 32'd1);

        // backpressure isolation on channel 3
        out_ready[0] = 8'hF7;
        send(0, 3, 8'h30, 1'b0);
        in_sel[0] = 3'd3; in_data[0] = 8'h31; in_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_ch3", 32'(in_ready[0]), 32'd0);
            check("bp_hold_ch3", 32'(out_data[0][3*8 +: 8]), 32'h30);
            @(posedge clk); #1;
        end
        send(0, 5, 8'h50, 1'b0);
        in_sel[0] = 3'd3; in_data[0] = 8'h31; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 8'hFF;
        send(0, 3, 8'h31, 1'b0);
        idle(2);
        check("bp_cnt_ch3", 32'(recv[0][3]), 32'd3);
        check("bp_cnt_ch5", 32'(recv[0][5]), 32'd2);

        // simultaneous drain and load on channel 1
        send(0, 1, 8'h11, 1'b0);
        send(0, 1, 8'h12, 1'b0);
        @(negedge clk);
        check("dl_valid1", 32'(out_valid[0][1]), 32'd1);
        check("dl_data1", 32'(out_data[0][1*8 +: 8]), 32'h12);
        idle(2);
        check("dl_cnt_ch1", 32'(recv[0][1]), 32'd3);

        // packet lock: first beat to ch2, later beats ask for ch6
        send(1, 2, 8'hC0, 1'b0);
        send(1, 6, 8'hC1, 1'b0);
        idle(3);
        send(1, 6, 8'hC2, 1'b0);
        send(1, 6, 8'hC3, 1'b1);
        idle(2);
        check("pkt_cnt_ch2", 32'(recv[1][2]), 32'd4);
        check("pkt_cnt_ch6", 32'(recv[1][6]), 32'd0);

        // reset mid-packet on channel 4
        out_ready[1] = 8'hEF;
        send(1, 4, 8'hD0, 1'b0);
        in_sel[1] = 3'd4; in_data[1] = 8'hD1; in_valid[1] = 1'b1; in_last[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid[1] = 1'b0;
        in_sel[1] = 3'd7;
        out_ready[1] = 8'hFF;
        @(negedge clk);
        check("rmp_valid", 32'(out_valid[1]), 32'd0);
        check("rmp_busy", 32'(busy[1]), 32'd0);
        check("rmp_cur_sel", 32'(cur_sel[1]), 32'd7);
        @(posedge clk); #1;
        send(1, 0, 8'hE0, 1'b1);
        @(negedge clk);
        check("single_busy", 32'(busy[1]), 32'd0);
        check("single_valid0", 32'(out_valid[1][0]), 32'd1);
        idle(2);

        // random traffic with random backpressure on both instances
        rnd_en = 1'b1;
        for (int b = 0; b < 300; b++) begin
            in_valid[0] = 1'($urandom_range(0, 3) != 0);
            in_sel[0]   = 3'($urandom);
            in_data[0]  = 8'($urandom);
            in_last[0]  = 1'($urandom);
            in_valid[1] = 1'($urandom_range(0, 3) != 0);
            in_sel[1]   = 3'($urandom);
            in_data[1]  = 8'($urandom);
            in_last[1]  = 1'($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
        end
        rnd_en = 1'b0;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        @(posedge clk); #2;
        out_ready[0] = 8'hFF; out_ready[1] = 8'hFF;
        idle(4);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++)
                check($sformatf("sb_empty%0d[%0d]", i, k), 32'(sb_q[i][k].size()), 32'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
